// File: rtl/bsg_manycore_fwd_sdr_credit_tx.sv
// Credit-based transmit stage for one manycore forward SDR uplink.
// Packets launch onto a registered link only while remote receive-FIFO credits remain.

// Flags a token pulse that arrives while the credit counter is already full.
module bsg_manycore_fwd_sdr_credit_tx_checker #(
  parameter int credit_w_p = 5,
  parameter int els_p      = 16
) (
  input logic                  clk_i,
  input logic                  reset_n_i,
  input logic                  token_i,
  input logic [credit_w_p-1:0] credits_i
);

  localparam logic [credit_w_p-1:0] els_lp = credit_w_p'(els_p);

  // no token may be returned while every credit is already home
  token_when_full_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(token_i && (credits_i == els_lp)))
    else $error("token_i pulsed while credits_o == els_p");

endmodule

module bsg_manycore_fwd_sdr_credit_tx #(
  parameter int width_p                 = 128,
  parameter int els_p                   = 16,
  parameter int token_decimation_p      = 4,
  parameter bit assert_token_overflow_p = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [width_p-1:0]         data_i,
  input  logic                       v_i,
  output logic                       ready_and_o,
  output logic [width_p-1:0]         link_data_o,
  output logic                       link_v_o,
  input  logic                       token_i,
  output logic [$clog2(els_p+1)-1:0] credits_o,
  output logic                       error_o
);

  localparam int credit_w_lp = $clog2(els_p+1);
  // one extra bit so credits + token_decimation_p cannot wrap before the overflow compare
  localparam int sum_w_lp    = credit_w_lp + 1;

  localparam logic [sum_w_lp-1:0]    els_sum_lp    = sum_w_lp'(els_p);
  localparam logic [sum_w_lp-1:0]    dec_sum_lp    = sum_w_lp'(token_decimation_p);
  localparam logic [sum_w_lp-1:0]    one_sum_lp    = sum_w_lp'(1);
  localparam logic [credit_w_lp-1:0] els_credit_lp = credit_w_lp'(els_p);

  if ((token_decimation_p < 1) || (token_decimation_p > els_p)
      || ((els_p % token_decimation_p) != 0)) begin : g_bad_params
    $error("token_decimation_p must divide els_p and not exceed it");
  end

  logic [width_p-1:0]     link_data_r;
  logic                   link_v_r;
  logic [credit_w_lp-1:0] credits_r;
  logic                   error_r;

  logic                   send_s;
  logic [sum_w_lp-1:0]    after_send_s;
  logic [sum_w_lp-1:0]    sum_s;
  logic                   overflow_s;
  logic [credit_w_lp-1:0] credits_next_s;

  assign ready_and_o = (credits_r != {credit_w_lp{1'b0}});
  assign link_data_o = link_data_r;
  assign link_v_o    = link_v_r;
  assign credits_o   = credits_r;
  assign error_o     = error_r;

  // Handshake qualification and the saturating credit update.
  always_comb begin
    send_s       = v_i & ready_and_o;
    after_send_s = {1'b0, credits_r};
    sum_s        = {1'b0, credits_r};
    if (send_s) begin
      after_send_s = {1'b0, credits_r} - one_sum_lp;
    end else begin
      after_send_s = {1'b0, credits_r};
    end
    if (token_i) begin
      sum_s = after_send_s + dec_sum_lp;
    end else begin
      sum_s = after_send_s;
    end
    overflow_s = (sum_s > els_sum_lp);
    if (overflow_s) begin
      credits_next_s = els_credit_lp;
    end else begin
      credits_next_s = sum_s[credit_w_lp-1:0];
    end
  end

  // Link register, credit counter and sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      link_data_r <= {width_p{1'b0}};
      link_v_r    <= 1'b0;
      credits_r   <= els_credit_lp;
      error_r     <= 1'b0;
    end else begin
      // link_data holds between packets so the uplink does not toggle when idle
      if (send_s) begin
        link_data_r <= data_i;
      end else begin
        link_data_r <= link_data_r;
      end
      link_v_r  <= send_s;
      credits_r <= credits_next_s;
      error_r   <= error_r | overflow_s;
    end
  end

  if (assert_token_overflow_p) begin : g_checker
    bsg_manycore_fwd_sdr_credit_tx_checker #(
      .credit_w_p (credit_w_lp),
      .els_p      (els_p)
    ) checker_inst (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .token_i   (token_i),
      .credits_i (credits_r)
    );
  end

endmodule

// File: tb/tb_bsg_manycore_fwd_sdr_credit_tx.sv
// Randomized self-checking bench for bsg_manycore_fwd_sdr_credit_tx against a
// credit/queue reference model and a 16-deep remote FIFO model.
module tb_bsg_manycore_fwd_sdr_credit_tx;

  localparam int W   = 128;
  localparam int ELS = 16;
  localparam int DEC = 4;

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          v_i = 1'b0;
  logic          ready_and_o;
  logic [W-1:0]  link_data_o;
  logic          link_v_o;
  logic          token_i = 1'b0;
  logic [4:0]    credits_o;
  logic          error_o;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  int           m_credits = 0;
  bit           m_err = 1'b0;
  bit           m_v = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] sent_q[$];
  int           n_link = 0;

  // overflow is injected on purpose below, so the full-credit token assertion is off
  bsg_manycore_fwd_sdr_credit_tx #(
    .width_p(W), .els_p(ELS), .token_decimation_p(DEC), .assert_token_overflow_p(1'b0)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .data_i(data_i), .v_i(v_i),
    .ready_and_o(ready_and_o), .link_data_o(link_data_o), .link_v_o(link_v_o),
    .token_i(token_i), .credits_o(credits_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // one clock: drive inputs, predict, clock, compare all outputs
  task automatic step(input bit rst, input bit v, input logic [W-1:0] d, input bit tok,
                      output bit snd);
    int nxt;
    reset_n_i = ~rst;
    v_i = v;
    data_i = d;
    token_i = tok;
    if (!rst) check_eq("ready", W'(ready_and_o), W'(m_credits != 0));
    snd = !rst && v && (m_credits != 0);
    @(posedge clk);
    #1;
    if (rst) begin
      m_v = 1'b0; m_data = '0; m_credits = ELS; m_err = 1'b0;
      sent_q.delete();
    end else begin
      m_v = snd;
      if (snd) begin
        m_data = d;
        sent_q.push_back(d);
      end
      nxt = m_credits - (snd ? 1 : 0) + (tok ? DEC : 0);
      if (nxt > ELS) begin
        nxt = ELS;
        m_err = 1'b1;
      end
      m_credits = nxt;
    end
    check_eq("link_v", W'(link_v_o), W'(m_v));
    check_eq("link_data", link_data_o, m_data);
    check_eq("credits", W'(credits_o), W'(m_credits));
    check_eq("error", W'(error_o), W'(m_err));
    if (link_v_o) begin
      n_link++;
      if (sent_q.size() == 0) check_eq("order_nonempty", W'(0), W'(1));
      else check_eq("order", link_data_o, sent_q.pop_front());
    end
  endtask

  initial begin
    bit snd;
    int n_hs;
    int first_v;
    logic [W-1:0] seq;
    int rx_occ;
    int drained;
    bit tok;

    // reset state
    step(1'b1, 1'b1, rand_data(), 1'b1, snd);
    step(1'b1, 1'b0, '0, 1'b0, snd);
    check_eq("rst_ready", W'(ready_and_o), W'(1));

    // 1: 20 cycles of v_i with no tokens -> exactly 16 handshakes
    n_hs = 0; n_link = 0; first_v = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, rand_data(), 1'b0, snd);
      if (snd) n_hs++;
      if (link_v_o && first_v < 0) first_v = i;
    end
    check_eq("t1_handshakes", W'(n_hs), W'(16));
    check_eq("t1_link_pulses", W'(n_link), W'(16));
    check_eq("t1_first_v_cycle", W'(first_v), W'(0));
    check_eq("t1_ready_low", W'(ready_and_o), W'(0));
    check_eq("t1_credits", W'(credits_o), W'(0));

    // 2: one token from empty -> 4 credits, 4 more packets, then stall
    step(1'b0, 1'b1, rand_data(), 1'b1, snd);
    check_eq("t2_credits4", W'(credits_o), W'(4));
    n_hs = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, rand_data(), 1'b0, snd);
      if (snd) n_hs++;
    end
    check_eq("t2_handshakes", W'(n_hs), W'(4));
    check_eq("t2_ready_low", W'(ready_and_o), W'(0));

    // 3: reach 1 credit, then send and token together -> 4
    step(1'b0, 1'b0, '0, 1'b1, snd);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rand_data(), 1'b0, snd);
    check_eq("t3_credits1", W'(credits_o), W'(1));
    seq = rand_data();
    step(1'b0, 1'b1, seq, 1'b1, snd);
    check_eq("t3_credits4", W'(credits_o), W'(4));
    check_eq("t3_link_v", W'(link_v_o), W'(1));
    check_eq("t3_link_data", link_data_o, seq);

    // 4: fill to 16, then an extra token saturates and sets the sticky error
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, rand_data(), 1'b1, snd);
    check_eq("t4_full", W'(credits_o), W'(16));
    step(1'b0, 1'b0, rand_data(), 1'b1, snd);
    check_eq("t4_sat", W'(credits_o), W'(16));
    check_eq("t4_err", W'(error_o), W'(1));
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, rand_data(), 1'b0, snd);
    check_eq("t4_err_sticky", W'(error_o), W'(1));

    // 5: mid-burst reset at 9 credits with link_v high
    check_eq("t5_pre_credits", W'(credits_o), W'(9));
    check_eq("t5_pre_v", W'(link_v_o), W'(1));
    step(1'b1, 1'b1, rand_data(), 1'b1, snd);
    check_eq("t5_v", W'(link_v_o), W'(0));
    check_eq("t5_data", link_data_o, W'(0));
    check_eq("t5_credits", W'(credits_o), W'(16));
    check_eq("t5_err", W'(error_o), W'(0));

    // 6: random traffic into a modelled 16-deep remote FIFO returning tokens
    seq = '0; rx_occ = 0; drained = 0; n_link = 0; n_hs = 0;
    for (int i = 0; i < 10000; i++) begin
      tok = (drained >= DEC);
      if (tok) drained -= DEC;
      step(1'b0, ($urandom_range(0, 3) != 0), seq, tok, snd);
      if (snd) begin
        seq++;
        n_hs++;
        rx_occ++;
      end
      check_eq("t6_credits_max", W'(credits_o <= 5'd16), W'(1));
      if (rx_occ > 0 && $urandom_range(0, 1) == 1) begin
        rx_occ--;
        drained++;
      end
    end
    step(1'b0, 1'b0, seq, 1'b0, snd);
    check_eq("t6_all_delivered", W'(n_link), W'(n_hs));
    check_eq("t6_queue_empty", W'(sent_q.size()), W'(0));
    check_eq("t6_err", W'(error_o), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
